// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops one byte per frame from the TX FIFO and serialises it as
// start, 5-8 data bits LSB first, optional parity and 1 or 2 stop bits on a 16x baud tick.
module uart_tx_ctrl #(
    parameter int unsigned OVS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       tx_en,
    input  logic [1:0] data_bits,
    input  logic       parity_en,
    input  logic       parity_even,
    input  logic       stop2,
    input  logic       txff_empty,
    input  logic [7:0] tx_data_out,
    output logic       tx_rd,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [TW-1:0] TickLast = TW'(OVS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e      state_q;
    logic [TW-1:0] tick_q;
    logic [2:0]  bit_idx_q;
    logic        stop_cnt_q;
    logic [7:0]  shreg_q;
    logic [1:0]  nbits_q;
    logic        par_en_q;
    logic        par_bit_q;
    logic        stop2_q;
    logic        tx_q;
    logic        tx_rd_q;
    logic        tx_busy_q;
    logic        frame_done_q;

    logic [7:0] cap_mask;
    logic       cap_parity;
    logic       bit_end;
    logic       last_bit;

    // Parity is fixed at capture so later config changes cannot disturb the frame.
    assign cap_mask   = 8'hFF >> (2'd3 - data_bits);
    assign cap_parity = (^(tx_data_out & cap_mask)) ^ ~parity_even;
    assign bit_end    = baud_tick && (tick_q == TickLast);
    assign last_bit   = (bit_idx_q == ({1'b0, nbits_q} + 3'd4));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shreg_q      <= '0;
            nbits_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            tx_q         <= 1'b1;
            tx_rd_q      <= 1'b0;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_rd_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (state_q != StIdle && baud_tick) begin
                tick_q <= bit_end ? '0 : tick_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (tx_en && !txff_empty) begin
                        state_q   <= StStart;
                        tx_rd_q   <= 1'b1;
                        shreg_q   <= tx_data_out;
                        nbits_q   <= data_bits;
                        par_en_q  <= parity_en;
                        par_bit_q <= cap_parity;
                        stop2_q   <= stop2;
                        tick_q    <= '0;
                        tx_q      <= 1'b0;
                        tx_busy_q <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shreg_q <= shreg_q >> 1;
                        if (last_bit) begin
                            if (par_en_q) begin
                                state_q <= StParity;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q    <= StStop;
                                stop_cnt_q <= 1'b0;
                                tx_q       <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shreg_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q    <= StStop;
                        stop_cnt_q <= 1'b0;
                        tx_q       <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (stop2_q && !stop_cnt_q) begin
                            stop_cnt_q <= 1'b1;
                        end else begin
                            state_q      <= StIdle;
                            frame_done_q <= 1'b1;
                            tx_busy_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    tx_q      <= 1'b1;
                    tx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_rd      = tx_rd_q;
    assign tx         = tx_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: FIFO model, per-frame bit-list reference model and
// tick-counting receiver checking every bit period, pops, busy and frame_done.
module tb_uart_tx_ctrl;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_en = 1'b0;
    logic [1:0] data_bits = 2'b11;
    logic       parity_en = 1'b0;
    logic       parity_even = 1'b0;
    logic       stop2 = 1'b0;
    logic       txff_empty = 1'b1;
    logic [7:0] tx_data_out = 8'h00;
    logic       tx_rd;
    logic       tx;
    logic       tx_busy;
    logic       frame_done;

    int   checks = 0;
    int   failures = 0;
    int   rd_cnt = 0;
    int   fd_cnt = 0;
    logic rd_prev = 1'b0;
    logic tick_seen = 1'b0;
    bit   rand_ticks = 1'b0;
    logic [7:0] fifo[$];
    bit   exp_q[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.OVS(OVS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_tick  (baud_tick),
        .tx_en      (tx_en),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_even(parity_even),
        .stop2      (stop2),
        .txff_empty (txff_empty),
        .tx_data_out(tx_data_out),
        .tx_rd      (tx_rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        txff_empty  = (fifo.size() == 0);
        tx_data_out = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: FIFO pops on the edge after a tx_rd cycle, so empty lags by one clk.
    task automatic step();
        @(posedge clk);
        tick_seen = baud_tick;
        if (rd_prev && fifo.size() > 0) void'(fifo.pop_front());
        #1;
        if (tx_rd === 1'b1) rd_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        rd_prev = tx_rd;
        refresh();
        baud_tick = rand_ticks ? ($urandom_range(0, 2) == 0) : 1'b1;
    endtask

    // Reference: the list of line levels, one per bit time.
    function automatic void build(input logic [7:0] d, input logic [1:0] db, input logic pe,
                                  input logic pev, input logic s2);
        int n;
        int ones;
        n = 5 + int'(db);
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) exp_q.push_back(pev ? (ones % 2 == 1) : (ones % 2 == 0));
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    task automatic check_frame(input string name, input logic [7:0] d, input logic [1:0] db,
                               input logic pe, input logic pev, input logic s2,
                               input int drop_at, output int wait_cyc);
        int cur;
        int cnt;
        int cyc;
        int rd0;
        bit ok;
        bit busy_ok;
        bit fd_early;
        data_bits   = db;
        parity_en   = pe;
        parity_even = pev;
        stop2       = s2;
        build(d, db, pe, pev, s2);
        wait_cyc = 0;
        while (tx_rd !== 1'b1 && wait_cyc < 2000) begin
            step();
            wait_cyc++;
        end
        chk({name, " pop"}, 32'(tx_rd), 32'd1);
        if (tx_rd !== 1'b1) return;
        rd0 = rd_cnt;
        // Scramble the config inputs: the frame in flight must ignore them.
        data_bits   = 2'($urandom);
        parity_en   = 1'($urandom);
        parity_even = 1'($urandom);
        stop2       = 1'($urandom);
        cur = 0;
        cnt = 0;
        cyc = 0;
        ok = 1'b1;
        busy_ok = 1'b1;
        fd_early = 1'b0;
        while (cur < exp_q.size() && cyc < 4000) begin
            if (tx !== exp_q[cur]) ok = 1'b0;
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
            if (frame_done !== 1'b0) fd_early = 1'b1;
            if (cur == drop_at) tx_en = 1'b0;
            step();
            cyc++;
            if (tick_seen) cnt++;
            if (cnt == OVS) begin
                chk($sformatf("%s d=%02h bit%0d", name, d, cur), 32'(ok), 32'd1);
                cur++;
                cnt = 0;
                ok = 1'b1;
            end
        end
        chk({name, " all_bits_seen"}, 32'(cur), 32'(exp_q.size()));
        chk({name, " busy_in_frame"}, 32'(busy_ok), 32'd1);
        chk({name, " no_early_done"}, 32'(fd_early), 32'd0);
        chk({name, " frame_done"}, 32'(frame_done), 32'd1);
        chk({name, " tx_idle"}, 32'(tx), 32'd1);
        chk({name, " busy_low"}, 32'(tx_busy), 32'd0);
        chk({name, " single_pop"}, 32'(rd_cnt - rd0), 32'd0);
        if (!rand_ticks) chk({name, " frame_clks"}, 32'(cyc), 32'(OVS * exp_q.size()));
    endtask

    initial begin
        int w;
        int rd0;
        int n;
        bit idle_ok;
        logic [7:0] d;
        logic [1:0] db;
        logic pe, pev, s2;

        reset_n = 1'b0;
        refresh();
        repeat (3) step();
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(tx_busy), 32'd0);
        chk("reset tx_rd", 32'(tx_rd), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;

        // Empty FIFO: nothing happens.
        tx_en = 1'b1;
        idle_ok = 1'b1;
        repeat (20) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("empty idle", 32'(idle_ok), 32'd1);
        chk("empty no pop", 32'(rd_cnt), 32'd0);

        fifo.push_back(8'hA5);
        refresh();
        check_frame("8N1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, -1, w);
        chk("8N1 pops", 32'(rd_cnt), 32'd1);

        fifo.push_back(8'h83);
        refresh();
        check_frame("7E2", 8'h83, 2'b10, 1'b1, 1'b1, 1'b1, -1, w);

        fifo.push_back(8'h1F);
        refresh();
        check_frame("5O1", 8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, -1, w);

        // Back-to-back with irregular baud ticks.
        rand_ticks = 1'b1;
        rd0 = rd_cnt;
        fifo.push_back(8'h11);
        fifo.push_back(8'h22);
        fifo.push_back(8'h33);
        refresh();
        check_frame("b2b0", 8'h11, 2'b11, 1'b0, 1'b0, 1'b0, -1, w);
        check_frame("b2b1", 8'h22, 2'b11, 1'b0, 1'b0, 1'b0, -1, w);
        chk("b2b1 gap", 32'(w), 32'd1);
        check_frame("b2b2", 8'h33, 2'b11, 1'b0, 1'b0, 1'b0, -1, w);
        chk("b2b2 gap", 32'(w), 32'd1);
        idle_ok = 1'b1;
        repeat (30) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("b2b idle after", 32'(idle_ok), 32'd1);
        chk("b2b pops", 32'(rd_cnt - rd0), 32'd3);

        // tx_en dropped during the 4th data bit: frame finishes, second byte stays queued.
        rand_ticks = 1'b0;
        rd0 = rd_cnt;
        fifo.push_back(8'h44);
        fifo.push_back(8'h55);
        refresh();
        check_frame("drop", 8'h44, 2'b11, 1'b0, 1'b0, 1'b0, 4, w);
        idle_ok = 1'b1;
        repeat (60) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("drop idle", 32'(idle_ok), 32'd1);
        chk("drop pops", 32'(rd_cnt - rd0), 32'd1);
        tx_en = 1'b1;
        check_frame("resume", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, -1, w);
        chk("resume pops", 32'(rd_cnt - rd0), 32'd2);

        // Reset in the middle of DATA.
        fifo.push_back(8'h66);
        fifo.push_back(8'h77);
        refresh();
        n = 0;
        while (tx_rd !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("rst first pop", 32'(tx_rd), 32'd1);
        repeat (40) step();
        chk("rst busy mid", 32'(tx_busy), 32'd1);
        rd0 = rd_cnt;
        reset_n = 1'b0;
        #1;
        chk("rst async tx", 32'(tx), 32'd1);
        chk("rst async busy", 32'(tx_busy), 32'd0);
        chk("rst async rd", 32'(tx_rd), 32'd0);
        repeat (3) step();
        chk("rst no pop", 32'(rd_cnt - rd0), 32'd0);
        reset_n = 1'b1;
        check_frame("after_rst", 8'h77, 2'b11, 1'b0, 1'b0, 1'b0, -1, w);

        // Random frames and configs.
        rand_ticks = 1'b1;
        repeat (6) begin
            d   = 8'($urandom);
            db  = 2'($urandom);
            pe  = 1'($urandom);
            pev = 1'($urandom);
            s2  = 1'($urandom);
            fifo.push_back(d);
            refresh();
            check_frame("rand", d, db, pe, pev, s2, -1, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer between the TX FIFO and the serial line. Pops one byte per frame from the FIFO and serialises it as start, 5-8 data bits (LSB first), optional parity, and 1 or 2 stop bits. Timing comes from an external 16x oversampling baud tick. Frames are sent back to back while the FIFO is non-empty and transmission is enabled.

Parameters:
OVS, 16, baud ticks per bit; tick counter width is clog2(OVS).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
baud_tick  in  1  one-clk pulse at OVS x baud rate
tx_en  in  1  transmit enable
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en  in  1  parity bit inserted when 1
parity_even  in  1  1=even parity, 0=odd parity
stop2  in  1  0=1 stop bit, 1=2 stop bits
txff_empty  in  1  FIFO empty flag
tx_data_out  in  8  FIFO head byte, combinational, valid whenever txff_empty=0
tx_rd  out  1  FIFO pop strobe, one clk
tx  out  1  serial line, idle high
tx_busy  out  1  high while a frame is in progress
frame_done  out  1  one-clk pulse at the end of the last stop bit

Behaviour:
- Reset (async, reset_n=0): state=IDLE, tx=1, tx_rd=0, tx_busy=0, frame_done=0, all counters and the shift register cleared. Reset mid-frame aborts the frame and tx returns to 1 immediately. No FIFO pop occurs during reset.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_busy=0.
  - If tx_en=1 and txff_empty=0, in the same clk:
    - assert tx_rd for exactly one cycle;
    - capture tx_data_out into the shift register;
    - latch data_bits, parity_en, parity_even, stop2 into frame-config registers;
    - clear the tick counter;
    - go to START.
  - Config changes mid-frame do not affect the current frame.
- Bit timing: the tick counter increments on each baud_tick. A bit ends on the baud_tick where the counter equals OVS-1; the counter then wraps to 0. tx changes in the clk after the state transition, and is registered with no glitches.
- START: tx=0 for OVS ticks, then DATA with bit index=0.
- DATA:
  - tx = shift register bit 0.
  - At bit end: shift right, increment index.
  - After bit N-1 (N = 5 + latched data_bits): go to PARITY if parity_en, else STOP.
- PARITY:
  - tx = XOR of the N transmitted data bits when even; inverted XOR when odd.
  - Compute the parity at capture from the masked byte; bits above N are ignored.
  - Lasts OVS ticks, then STOP.
- STOP:
  - tx=1 for OVS ticks (1 stop) or 2*OVS ticks (2 stop); use a stop-bit counter.
  - At the end: pulse frame_done for one clk and return to IDLE.
- Back-to-back frames: if the FIFO is non-empty and tx_en=1, the pop happens in the first IDLE cycle. The gap between frames is exactly 1 clk; no extra idle bit time is inserted.
- tx_busy=1 in START, DATA, PARITY and STOP.
- tx_en deasserted mid-frame: the current frame completes, then the block stays in IDLE without popping.
- FIFO empty flag lag: txff_empty updates one clk after tx_rd. tx_rd is never asserted outside the IDLE->START transition, so a double pop is impossible.
- Empty FIFO: no tx_rd pulse, tx held at 1.
- baud_tick asserted in the same clk as the capture: not counted; counting starts in START.

Test Plan:
- 8N1, FIFO holds 0xA5 (OVS=16, tick every clk) -> one tx_rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; frame_done after 160 ticks; tx_busy high throughout.
- 7E2, byte 0x83 -> data bits 1,1,0,0,0,0,0, parity=0, two stop bits of 16 ticks each; the top bit of 0x83 is not sent; total 176 ticks.
- 5O1, byte 0x1F -> data 1,1,1,1,1, parity=0 (odd); 8 bit-times total.
- FIFO preloaded with 3 bytes (0x11, 0x22, 0x33) -> exactly 3 tx_rd pulses, each 1 clk after the preceding frame_done; bytes sent in order; idle afterwards with tx=1.
- tx_en dropped at the 4th data bit of frame 1 with a 2nd byte queued -> frame 1 completes; no second tx_rd; tx stays at 1. Re-assert tx_en -> the 2nd byte pops.
- reset_n pulsed low in the middle of DATA -> tx=1 asynchronously, tx_busy=0, state IDLE. After release with a non-empty FIFO, a new frame starts with a fresh pop.
